// File: rtl/dram_port_arbiter.sv
// Two-master round-robin arbiter for the external DRAM port: one posted request
// per master, single-cycle DRAM strobe, wait for dram_ack with timeout, ack back.
module dram_port_arbiter #(
   parameter int ADDR_BITS  = 22,
   parameter int DATA_BITS  = 32,
   parameter int TIMEOUT    = 1000,
   parameter int TIMER_BITS = 10
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sync_reset,
   input  logic                   m0_rd_en,
   input  logic                   m0_wr_en,
   input  logic [ADDR_BITS-1:0]   m0_addr,
   input  logic [DATA_BITS/8-1:0] m0_be,
   input  logic [DATA_BITS-1:0]   m0_wdata,
   output logic                   m0_busy,
   output logic                   m0_ack,
   output logic                   m0_err,
   output logic [DATA_BITS-1:0]   m0_rdata,
   output logic                   m0_ovf,
   input  logic                   m1_rd_en,
   input  logic                   m1_wr_en,
   input  logic [ADDR_BITS-1:0]   m1_addr,
   input  logic [DATA_BITS/8-1:0] m1_be,
   input  logic [DATA_BITS-1:0]   m1_wdata,
   output logic                   m1_busy,
   output logic                   m1_ack,
   output logic                   m1_err,
   output logic [DATA_BITS-1:0]   m1_rdata,
   output logic                   m1_ovf,
   output logic [ADDR_BITS-1:0]   dram_mem_addr,
   output logic                   dram_mem_read_en,
   output logic                   dram_mem_write_en,
   output logic [DATA_BITS/8-1:0] dram_mem_byte_enable,
   output logic [DATA_BITS-1:0]   dram_mem_write_data,
   input  logic                   dram_ack,
   input  logic [DATA_BITS-1:0]   dram_mem_read_data
);
   localparam int BE_BITS = DATA_BITS / 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                         state_q, state_d;
   logic [1:0]                     req_v, req_wr;
   logic [1:0][ADDR_BITS-1:0]      req_addr, addr_q, addr_d;
   logic [1:0][BE_BITS-1:0]        req_be, be_q, be_d;
   logic [1:0][DATA_BITS-1:0]      req_wdata, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]                     pend_q, pend_d, wr_q, wr_d, ovf_q, ovf_d;
   logic [1:0]                     ack_q, ack_d, err_q, err_d, clr;
   logic                           last_q, last_d, gnt_q, gnt_d, g, done, done_err;
   logic [TIMER_BITS-1:0]          timer_q, timer_d;
   logic [ADDR_BITS-1:0]           daddr_q, daddr_d;
   logic                           drd_q, drd_d, dwr_q, dwr_d;
   logic [BE_BITS-1:0]             dbe_q, dbe_d;
   logic [DATA_BITS-1:0]           dwd_q, dwd_d;

   // Write wins when rd_en and wr_en arrive together.
   assign req_v     = {m1_rd_en | m1_wr_en, m0_rd_en | m0_wr_en};
   assign req_wr    = {m1_wr_en, m0_wr_en};
   assign req_addr  = {m1_addr, m0_addr};
   assign req_be    = {m1_be, m0_be};
   assign req_wdata = {m1_wdata, m0_wdata};

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      ovf_d    = ovf_q;
      rdata_d  = rdata_q;
      ack_d    = '0;
      err_d    = '0;
      last_d   = last_q;
      gnt_d    = gnt_q;
      timer_d  = timer_q;
      daddr_d  = daddr_q;
      dbe_d    = dbe_q;
      dwd_d    = dwd_q;
      drd_d    = 1'b0;
      dwr_d    = 1'b0;
      g        = 1'b0;
      done     = 1'b0;
      done_err = 1'b0;
      clr      = '0;

      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               g       = (&pend_q) ? ~last_q : pend_q[1];
               gnt_d   = g;
               last_d  = g;
               daddr_d = addr_q[g];
               dbe_d   = be_q[g];
               dwd_d   = wdata_q[g];
               drd_d   = ~wr_q[g];
               dwr_d   = wr_q[g];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            if (dram_ack) done = 1'b1;
            else          state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dram_ack) begin
               done = 1'b1;
            end else if (timer_q == TIMER_BITS'(TIMEOUT - 1)) begin
               done     = 1'b1;
               done_err = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (done) begin
         ack_d[gnt_q]   = 1'b1;
         err_d[gnt_q]   = done_err;
         rdata_d[gnt_q] = (done_err || wr_q[gnt_q]) ? '0 : dram_mem_read_data;
         clr[gnt_q]     = 1'b1;
         state_d        = S_IDLE;
      end

      // Slot clear and capture never collide: capture needs the slot idle.
      for (int n = 0; n < 2; n++) begin
         if (clr[n]) pend_d[n] = 1'b0;
         if (req_v[n]) begin
            if (pend_q[n]) begin
               ovf_d[n] = 1'b1;
            end else begin
               pend_d[n]  = 1'b1;
               wr_d[n]    = req_wr[n];
               addr_d[n]  = req_addr[n];
               be_d[n]    = req_be[n];
               wdata_d[n] = req_wdata[n];
            end
         end
      end

      if (sync_reset) begin
         state_d = S_IDLE;
         pend_d  = '0;
         wr_d    = '0;
         addr_d  = '0;
         be_d    = '0;
         wdata_d = '0;
         ovf_d   = '0;
         rdata_d = '0;
         ack_d   = '0;
         err_d   = '0;
         last_d  = 1'b1;
         gnt_d   = 1'b0;
         timer_d = '0;
         daddr_d = '0;
         dbe_d   = '0;
         dwd_d   = '0;
         drd_d   = 1'b0;
         dwr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         wr_q    <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         ovf_q   <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         timer_q <= '0;
         daddr_q <= '0;
         dbe_q   <= '0;
         dwd_q   <= '0;
         drd_q   <= 1'b0;
         dwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         timer_q <= timer_d;
         daddr_q <= daddr_d;
         dbe_q   <= dbe_d;
         dwd_q   <= dwd_d;
         drd_q   <= drd_d;
         dwr_q   <= dwr_d;
      end
   end

   assign m0_busy              = pend_q[0];
   assign m1_busy              = pend_q[1];
   assign m0_ack               = ack_q[0];
   assign m1_ack               = ack_q[1];
   assign m0_err               = err_q[0];
   assign m1_err               = err_q[1];
   assign m0_rdata             = rdata_q[0];
   assign m1_rdata             = rdata_q[1];
   assign m0_ovf               = ovf_q[0];
   assign m1_ovf               = ovf_q[1];
   assign dram_mem_addr        = daddr_q;
   assign dram_mem_read_en     = drd_q;
   assign dram_mem_write_en    = dwr_q;
   assign dram_mem_byte_enable = dbe_q;
   assign dram_mem_write_data  = dwd_q;
endmodule
